// File: rtl/kbd_event_fifo_if.sv
// Event/CPU-side signal bundle for the keyboard event FIFO.
// The master drives events, read acks and overflow clear; the FIFO returns the status word.
interface kbd_event_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  ev_scancode;
  logic        ev_shift;
  logic        ev_valid;
  logic        rd_ack;
  logic        clr_ovf;
  logic [15:0] keyboard_data;
  logic [AW:0] count;

  modport master (
    output ev_scancode, ev_shift, ev_valid, rd_ack, clr_ovf,
    input  keyboard_data, count
  );

  modport slave (
    input  ev_scancode, ev_shift, ev_valid, rd_ack, clr_ovf,
    output keyboard_data, count
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through FIFO of {shift, scancode} keyboard events with sticky overflow.
// The head entry is always presented on keyboard_data; a rising edge of rd_ack pops it.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  kbd_event_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf, ack_q;

  logic full, ready, pop_req, do_pop, do_push, ovf_set;
  logic [8:0] head;

  assign full    = (cnt == FULL_CNT);
  assign ready   = (cnt != '0);
  assign pop_req = bus.rd_ack & ~ack_q;
  assign do_pop  = pop_req & ready;
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_push = bus.ev_valid & (~full | do_pop);
  assign ovf_set = bus.ev_valid & full & ~do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= bus.rd_ack;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      if (ovf_set)          ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {bus.ev_shift, bus.ev_scancode};
  end

  assign head              = ready ? mem[rd_ptr] : 9'h000;
  assign bus.keyboard_data = {5'b0, ovf, ready, head};
  assign bus.count         = cnt;
endmodule

// File: tb/tb_kbd_event_fifo.sv
// Directed bench for kbd_event_fifo against a queue-based model of the event buffer.
module tb_kbd_event_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #20 clk = ~clk;

  kbd_event_fifo_if #(.DEPTH(DEPTH)) bus();
  kbd_event_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [8:0] mq[$];
  logic [8:0] popped[$];
  logic       m_ovf;
  logic       m_prev_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_kbd();
    logic [8:0] h;
    h = (mq.size() != 0) ? mq[0] : 9'h000;
    return {5'b0, m_ovf, (mq.size() != 0), h};
  endfunction

  task automatic compare();
    chk("keyboard_data", 32'(bus.keyboard_data), 32'(model_kbd()));
    chk("count", 32'(bus.count), 32'(mq.size()));
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_prev_ack = 1'b0;
  endtask

  // Apply inputs for one clock, advance the model by the FIFO rules, then compare.
  task automatic cycle(input logic v, input logic [7:0] sc, input logic sh,
                       input logic ack, input logic clr);
    logic pop, full, drop;
    bus.ev_valid = v; bus.ev_scancode = sc; bus.ev_shift = sh;
    bus.rd_ack = ack; bus.clr_ovf = clr;
    @(posedge clk);
    #1;
    full = (mq.size() == DEPTH);
    pop = ack && !m_prev_ack && (mq.size() != 0);
    m_prev_ack = ack;
    drop = 1'b0;
    if (pop) popped.push_back(mq.pop_front());
    if (v) begin
      if (!full || pop) mq.push_back({sh, sc});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    compare();
  endtask

  task automatic push(input logic [7:0] sc, input logic sh);
    cycle(1'b1, sc, sh, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    model_clear();
    compare();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare();
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.ev_valid = 1'b0; bus.ev_scancode = 8'h00; bus.ev_shift = 1'b0;
    bus.rd_ack = 1'b0; bus.clr_ovf = 1'b0;
    model_clear();

    // Reset then idle, including a lone ack on an empty FIFO
    do_reset(3);
    idle(2);
    chk("reset_kbd_lit", 32'(bus.keyboard_data), 32'h0000);
    chk("reset_cnt_lit", 32'(bus.count), 0);
    pop_one();
    chk("empty_pop_lit", 32'(bus.keyboard_data), 32'h0000);

    // Single event, ack held high for 5 cycles pops only once
    push(8'h1C, 1'b1);
    chk("single_kbd_lit", 32'(bus.keyboard_data), 32'h031C);
    chk("single_cnt_lit", 32'(bus.count), 1);
    popped.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("single_pops", 32'(popped.size()), 1);
    chk("single_after_lit", 32'(bus.keyboard_data), 32'h0000);

    // Ordering across pointer wrap
    popped.delete();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) pop_one();
    for (int i = 6; i < 12; i++) push(8'h10 + 8'(i), 1'b0);
    chk("wrap_cnt_lit", 32'(bus.count), 8);
    while (mq.size() != 0) pop_one();
    chk("wrap_npop", 32'(popped.size()), 12);
    for (int i = 0; i < 12 && i < popped.size(); i++)
      chk("wrap_order", 32'(popped[i]), 32'h10 + 32'(i));
    chk("wrap_ovf_lit", 32'(bus.keyboard_data[10]), 0);

    // Overflow: ninth event dropped, ovf sticky until cleared
    popped.delete();
    for (int i = 0; i < 9; i++) push(8'h20 + 8'(i), 1'b0);
    chk("ovf_cnt_lit", 32'(bus.count), 8);
    chk("ovf_bit_lit", 32'(bus.keyboard_data[10]), 1);
    for (int i = 0; i < 9; i++) pop_one();
    chk("ovf_npop", 32'(popped.size()), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk("ovf_order", 32'(popped[i]), 32'h20 + 32'(i));
    chk("ovf_sticky_lit", 32'(bus.keyboard_data[10]), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_lit", 32'(bus.keyboard_data[10]), 0);

    // Full FIFO with same-cycle push and pop
    popped.delete();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("fullpp_cnt_lit", 32'(bus.count), 8);
    chk("fullpp_ovf_lit", 32'(bus.keyboard_data[10]), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pop_one();
    chk("fullpp_npop", 32'(popped.size()), 9);
    if (popped.size() == 9) chk("fullpp_last", 32'(popped[8]), 32'h055);

    // Reset mid-stream, then confirm a fresh push
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1);
    chk("mid_cnt_lit", 32'(bus.count), 5);
    do_reset(1);
    chk("mid_rst_cnt_lit", 32'(bus.count), 0);
    chk("mid_rst_kbd_lit", 32'(bus.keyboard_data), 32'h0000);
    push(8'h33, 1'b0);
    chk("mid_push_lit", 32'(bus.keyboard_data), 32'h0233);

    // rd_ack high through reset release must not pop anything stored later
    bus.rd_ack = 1'b1;
    do_reset(2);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ackhold_kbd_lit", 32'(bus.keyboard_data), 32'h0244);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
